// File: rtl/knapsack_entry_player_pkg.sv
// Shared definitions for the knapsack front-panel entry player and the blocks
// that reuse its timing and encodings.
package knapsack_defs;

  localparam int HOLD_DEFAULT   = 50;
  localparam int DATA_W_DEFAULT = 4;
  localparam int MAX_ITEMS      = 4;

  typedef enum logic [3:0] {
    IDLE,
    U_HI,
    U_LO,
    WAIT,
    C_HI,
    C_LO,
    R_HI,
    R_LO,
    DONE
  } state_e;

endpackage

// File: rtl/knapsack_entry_player_hold_timer.sv
// Phase counter: counts 0..HOLD-1 while enabled and flags the final cycle of
// a phase. Shared with the button debouncer.
module hold_timer
  import knapsack_defs::*;
#(
  parameter int HOLD = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int               CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assigned first so every path writes cnt_d; no latch inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/knapsack_entry_player.sv
// Drives the solver's switch/button entry sequence (u, then c/r per value)
// from a valid/ready value stream, with every button level held HOLD cycles.
module knapsack_entry_player
  import knapsack_defs::*;
#(
  parameter int HOLD   = HOLD_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_sw,
  output logic              out_signal_c,
  output logic              out_signal_r,
  output logic              out_signal_u,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sw_q, sw_d;
  logic              last_q, last_d;
  logic              timer_en;
  logic              timer_clr;
  logic              expire;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    last_d   = last_q;
    timer_en = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = clear ? U_HI : WAIT;
      U_HI: begin
        timer_en = 1'b1;
        if (expire) state_d = U_LO;
      end
      U_LO: begin
        timer_en = 1'b1;
        if (expire) state_d = WAIT;
      end
      WAIT: if (in_valid) begin
        sw_d    = in_data;
        last_d  = in_last;
        state_d = C_HI;
      end
      C_HI: begin
        timer_en = 1'b1;
        if (expire) state_d = C_LO;
      end
      C_LO: begin
        timer_en = 1'b1;
        if (expire) state_d = R_HI;
      end
      R_HI: begin
        timer_en = 1'b1;
        if (expire) state_d = R_LO;
      end
      R_LO: begin
        timer_en = 1'b1;
        if (expire) state_d = last_q ? DONE : WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each phase starts its hold count from zero.
  assign timer_clr = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sw_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      last_q  <= last_d;
    end
  end

  // Outputs are decoded from registered state only, so at most one button is high.
  assign in_ready     = (state_q == WAIT);
  assign out_sw       = sw_q;
  assign out_signal_u = (state_q == U_HI);
  assign out_signal_c = (state_q == C_HI);
  assign out_signal_r = (state_q == R_HI);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_knapsack_entry_player.sv
// Bench for knapsack_entry_player: timeline model checked every cycle plus
// directed sessions with hand-computed pulse lengths and counts.
module tb_knapsack_entry_player;

  localparam int H = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [3:0] out_sw;
  logic       out_signal_c;
  logic       out_signal_r;
  logic       out_signal_u;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  knapsack_entry_player #(
    .HOLD   (H),
    .DATA_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_sw       (out_sw),
    .out_signal_c (out_signal_c),
    .out_signal_r (out_signal_r),
    .out_signal_u (out_signal_u),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Timeline model: outputs follow from the cycle offset since the last anchor edge.
  typedef enum int {M_IDLE, M_CLR, M_WAIT, M_VAL, M_DONE} mode_e;
  mode_e      m_mode = M_IDLE;
  int         m_k    = 0;
  logic [3:0] m_sw   = '0;
  bit         m_last = 1'b0;
  bit         cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= M_IDLE;
      m_k    <= 0;
      m_sw   <= '0;
      m_last <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode <= clear ? M_CLR : M_WAIT;
          m_k    <= 0;
        end
        M_CLR: if (m_k + 1 == 2 * H) m_mode <= M_WAIT;
        M_WAIT: if (in_valid) begin
          m_mode <= M_VAL;
          m_k    <= 0;
          m_sw   <= in_data;
          m_last <= in_last;
        end
        M_VAL: if (m_k + 1 == 4 * H) m_mode <= m_last ? M_DONE : M_WAIT;
        M_DONE: m_mode <= M_IDLE;
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_outputs",
            {22'd0, out_sw, out_signal_c, out_signal_r, out_signal_u, in_ready, busy, done},
            {22'd0, m_sw,
             (m_mode == M_VAL) && (m_k < H),
             (m_mode == M_VAL) && (m_k >= 2 * H) && (m_k < 3 * H),
             (m_mode == M_CLR) && (m_k < H),
             (m_mode == M_WAIT),
             (m_mode != M_IDLE),
             (m_mode == M_DONE)});
    end
  end

  // Event monitor: pulse counts, captured switch values, handshake/button overlap.
  int         c_rises = 0, r_rises = 0, u_rises = 0, done_cnt = 0, viol = 0;
  logic [3:0] cap_q[$];
  logic       prev_c = 1'b0, prev_r = 1'b0, prev_u = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (out_signal_c && !prev_c) begin
        c_rises++;
        cap_q.push_back(out_sw);
      end
      if (out_signal_r && !prev_r) r_rises++;
      if (out_signal_u && !prev_u) u_rises++;
      if (done) done_cnt++;
      if ((in_ready && (out_signal_c || out_signal_r || out_signal_u)) ||
          (int'(out_signal_c) + int'(out_signal_r) + int'(out_signal_u) > 1)) viol++;
      prev_c = out_signal_c;
      prev_r = out_signal_r;
      prev_u = out_signal_u;
    end
  end

  function automatic bit get_sig(input int which);
    case (which)
      0:       return out_signal_c;
      1:       return out_signal_r;
      2:       return out_signal_u;
      3:       return in_ready;
      4:       return done;
      default: return busy;
    endcase
  endfunction

  // All tasks start and end on a falling edge.
  task automatic run_len(input int which, input bit lvl, output int n);
    n = 0;
    while (get_sig(which) == lvl && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start(input bit clr);
    start = 1'b1;
    clear = clr;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  logic [3:0] vals[14] = '{4'd4, 4'd10, 4'd6, 4'd4, 4'd4, 4'd2, 4'd15,
                           4'd4, 4'd6, 4'd1, 4'd8, 4'd3, 4'd12, 4'd9};

  initial begin
    int n;
    int c0, r0, u0, d0, v0, stall;
    reset    = 1'b1;
    start    = 1'b1;
    clear    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;

    // Reset held 3 cycles with start asserted throughout.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    check("reset_outputs",
          {out_sw, out_signal_c, out_signal_r, out_signal_u, in_ready, busy, done}, 10'd0);
    repeat (3) @(negedge clk);
    check("reset_start_ignored", busy, 1'b0);

    // Clear pulse, then one value to close the session.
    pulse_start(1'b1);
    run_len(2, 1'b1, n);
    check("u_high_len", n, H);
    run_len(3, 1'b0, n);
    check("u_low_len", n, H);
    send(4'd3, 1'b1);
    wait_done();

    // Single value without clear.
    pulse_start(1'b0);
    send(4'b1100, 1'b1);
    check("single_sw", out_sw, 4'b1100);
    run_len(0, 1'b1, n);
    check("c_high_len", n, H);
    run_len(1, 1'b0, n);
    check("c_low_len", n, H);
    run_len(1, 1'b1, n);
    check("r_high_len", n, H);
    run_len(4, 1'b0, n);
    check("r_low_len", n, H);
    @(negedge clk);
    check("single_idle", {done, busy}, 2'b00);
    check("single_sw_hold", out_sw, 4'b1100);

    // Full 14-value session with a 37-cycle host stall before the sixth value.
    c0 = c_rises; r0 = r_rises; d0 = done_cnt; v0 = viol;
    cap_q.delete();
    pulse_start(1'b1);
    for (int i = 0; i < 14; i++) begin
      if (i == 5) begin
        n = 0;
        while (!in_ready && n < 1000) begin
          @(negedge clk);
          n++;
        end
        stall = 0;
        repeat (37) begin
          if (in_ready && !out_signal_c && !out_signal_r && !out_signal_u) stall++;
          @(negedge clk);
        end
        check("stall_ready_cycles", stall, 37);
      end
      send(vals[i], i == 13);
    end
    wait_done();
    check("session_c_pulses", c_rises - c0, 14);
    check("session_r_pulses", r_rises - r0, 14);
    check("session_done", done_cnt - d0, 1);
    check("session_overlap", viol - v0, 0);
    check("session_cap_count", cap_q.size(), 14);
    for (int i = 0; i < 14 && i < cap_q.size(); i++) check("session_cap_sw", cap_q[i], vals[i]);
    check("session_sw_hold", out_sw, 4'd9);

    // Reset in the middle of R_HI aborts at once.
    d0 = done_cnt;
    pulse_start(1'b0);
    send(4'd5, 1'b0);
    run_len(1, 1'b0, n);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_r_low", out_signal_r, 1'b0);
    check("abort_idle", {busy, in_ready, done}, 3'b000);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // start during C_LO has no effect.
    pulse_start(1'b0);
    send(4'd7, 1'b1);
    run_len(0, 1'b1, n);
    u0 = u_rises;
    d0 = done_cnt;
    pulse_start(1'b1);
    wait_done();
    repeat (5) @(negedge clk);
    check("ignored_start_u", u_rises - u0, 0);
    check("ignored_start_done", done_cnt - d0, 1);
    check("ignored_start_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
